// File: rtl/debounce_multi.sv
// N-channel button debouncer: per-channel synchroniser, stability counter, press/release pulses.
// Define AUTO_REPEAT_EN to add per-channel auto-repeat pulses on btn_rep while a button is held.

module debounce_multi_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic rep_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // any sample that agrees with the debounced state restarts the count
    if (s != out_q) begin
      if (cnt_q == LAST) begin
        out_d  = ~out_q;
        rise_d = ~out_q;
        fall_d = out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rep_q, rep_d;

  // counter holds cycles remaining until the next repeat; reloads at 1
  always_comb begin
    rcnt_d = '0;
    rep_d  = 1'b0;
    if (rise_d) begin
      rcnt_d = RW'(REPEAT_DELAY);
    end else if (out_d) begin
      if (rcnt_q == RW'(1)) begin
        rep_d  = 1'b1;
        rcnt_d = RW'(REPEAT_PERIOD);
      end else begin
        rcnt_d = rcnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
    end
  end

  assign rep_o = rep_q;
`else
  assign rep_o = 1'b0;
`endif
endmodule

module debounce_multi #(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 25
) (
  input  logic         CLK100HZ,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_out,
  output logic [N-1:0] btn_rise,
  output logic [N-1:0] btn_fall,
  output logic [N-1:0] btn_rep
);
  for (genvar g = 0; g < N; g++) begin : g_lane
    debounce_multi_lane #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .clk_i (CLK100HZ),
      .rst_i (rst),
      .btn_i (btn_in[g]),
      .out_o (btn_out[g]),
      .rise_o(btn_rise[g]),
      .fall_o(btn_fall[g]),
      .rep_o (btn_rep[g])
    );
  end
endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected outputs per cycle, a monitor checks them.
module tb_debounce_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_out, btn_rise, btn_fall, btn_rep;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rep;
    string      name;
  } exp_t;

  exp_t q[$];

  debounce_multi #(
    .N(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .CLK100HZ(clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_rep (btn_rep)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every queued entry due this cycle; any pulse not covered is flagged
  always @(negedge clk) begin
    logic matched;
    matched = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        checks++;
        matched = 1'b1;
        if (btn_out !== q[i].out || btn_rise !== q[i].rise ||
            btn_fall !== q[i].fall || btn_rep !== q[i].rep) begin
          errors++;
          $display("FAIL %s @%0d: got out=%b rise=%b fall=%b rep=%b, want out=%b rise=%b fall=%b rep=%b",
                   q[i].name, cyc, btn_out, btn_rise, btn_fall, btn_rep,
                   q[i].out, q[i].rise, q[i].fall, q[i].rep);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expected at cycle %0d never checked", q[i].name, q[i].cyc);
        q.delete(i);
      end
    end
    if (!matched && ((|btn_rise) || (|btn_fall) || (|btn_rep))) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse @%0d: rise=%b fall=%b rep=%b, want 0000", cyc, btn_rise, btn_fall, btn_rep);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int dt, input logic [3:0] o, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] p, input string nm);
    exp_t e;
    e.cyc = cyc + dt; e.out = o; e.rise = r; e.fall = f; e.rep = p; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 4'hF;
    expect_at(1, 4'h0, 4'h0, 4'h0, 4'h0, "rst_e1");
    expect_at(2, 4'h0, 4'h0, 4'h0, 4'h0, "rst_e2");
    expect_at(3, 4'h0, 4'h0, 4'h0, 4'h0, "rst_e3");
    tick(3);
    rst = 1'b0;
    expect_at(5, 4'h0, 4'h0, 4'h0, 4'h0, "rst_pre");
    expect_at(6, 4'hF, 4'hF, 4'h0, 4'h0, "rst_rise");
    expect_at(7, 4'hF, 4'h0, 4'h0, 4'h0, "rst_hold");
    tick(10);
    btn_in = 4'h0;
    expect_at(6, 4'h0, 4'h0, 4'hF, 4'h0, "all_fall");
    tick(10);

    // clean press / release on channel 0
    btn_in = 4'b0001;
    expect_at(5, 4'h0, 4'h0, 4'h0, 4'h0, "press_pre");
    expect_at(6, 4'h1, 4'h1, 4'h0, 4'h0, "press_rise");
    expect_at(7, 4'h1, 4'h0, 4'h0, 4'h0, "press_one");
    tick(12);
    btn_in = 4'b0000;
    expect_at(6, 4'h0, 4'h0, 4'h1, 4'h0, "release_fall");
    expect_at(7, 4'h0, 4'h0, 4'h0, 4'h0, "release_one");
    tick(10);

    // bounce only: high 3, low 2, high 2, low
    btn_in = 4'b0001; tick(3);
    btn_in = 4'b0000; tick(2);
    btn_in = 4'b0001; tick(2);
    btn_in = 4'b0000;
    expect_at(8, 4'h0, 4'h0, 4'h0, 4'h0, "bounce_idle");
    tick(10);

    // bounce then settle: high 2, low 1, high held
    btn_in = 4'b0001; tick(2);
    btn_in = 4'b0000; tick(1);
    btn_in = 4'b0001;
    expect_at(5, 4'h0, 4'h0, 4'h0, 4'h0, "settle_pre");
    expect_at(6, 4'h1, 4'h1, 4'h0, 4'h0, "settle_rise");
    tick(10);
    btn_in = 4'b0000;
    expect_at(6, 4'h0, 4'h0, 4'h1, 4'h0, "settle_fall");
    tick(10);

    // simultaneous rise on ch1 and fall on ch2
    btn_in = 4'b0100;
    expect_at(6, 4'b0100, 4'b0100, 4'h0, 4'h0, "simul_setup");
    tick(10);
    btn_in = 4'b0010;
    expect_at(5, 4'b0100, 4'h0, 4'h0, 4'h0, "simul_pre");
    expect_at(6, 4'b0010, 4'b0010, 4'b0100, 4'h0, "simul_both");
    expect_at(7, 4'b0010, 4'h0, 4'h0, 4'h0, "simul_after");
    tick(10);
    btn_in = 4'b0000;
    expect_at(6, 4'h0, 4'h0, 4'b0010, 4'h0, "simul_fall");
    tick(10);

    // reset while ch3 counter is at 2
    btn_in = 4'b1000;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_at(1, 4'h0, 4'h0, 4'h0, 4'h0, "rstmid_discard");
    expect_at(5, 4'h0, 4'h0, 4'h0, 4'h0, "rstmid_pre");
    expect_at(6, 4'b1000, 4'b1000, 4'h0, 4'h0, "rstmid_rise");
    tick(10);
    btn_in = 4'b0000;
    expect_at(6, 4'h0, 4'h0, 4'b1000, 4'h0, "rstmid_fall");
    tick(10);

`ifdef AUTO_REPEAT_EN
    // hold ch0: rise at +6, repeats at rise+10/+15/+20/+25, fall lands where rise+30 would be
    btn_in = 4'b0001;
    expect_at(6,  4'h1, 4'h1, 4'h0, 4'h0, "rep_rise");
    expect_at(15, 4'h1, 4'h0, 4'h0, 4'h0, "rep_pre");
    expect_at(16, 4'h1, 4'h0, 4'h0, 4'h1, "rep_first");
    expect_at(21, 4'h1, 4'h0, 4'h0, 4'h1, "rep_second");
    expect_at(26, 4'h1, 4'h0, 4'h0, 4'h1, "rep_third");
    expect_at(31, 4'h1, 4'h0, 4'h0, 4'h1, "rep_fourth");
    tick(30);
    btn_in = 4'b0000;
    expect_at(6, 4'h0, 4'h0, 4'h1, 4'h0, "rep_fall");
    expect_at(7, 4'h0, 4'h0, 4'h0, 4'h0, "rep_after");
    tick(12);
`else
    // without auto-repeat a long hold must produce no btn_rep
    btn_in = 4'b0001;
    expect_at(6,  4'h1, 4'h1, 4'h0, 4'h0, "hold_rise");
    expect_at(16, 4'h1, 4'h0, 4'h0, 4'h0, "hold_norep");
    tick(30);
    btn_in = 4'b0000;
    expect_at(6, 4'h0, 4'h0, 4'h1, 4'h0, "hold_fall");
    tick(12);
`endif

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
